// File: rtl/down_counter_timer.sv
// Loadable down-counting timer: load/start handshake, prescaled decrement, one-cycle done pulse on terminal count.
// Optional periodic reload on terminal count when DOWN_COUNTER_TIMER_AUTO_RELOAD_EN is defined.
module down_counter_timer #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             zero
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [PW-1:0]    presc, presc_nxt;
    logic             done_nxt;
    logic             tick;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload, reload_nxt;
`endif

    // With PRESCALE == 1 every enabled cycle is a tick and presc stays at zero.
    generate
        if (PRESCALE > 1) begin : g_presc
            assign tick = (presc == PW'(PRESCALE - 1));
        end else begin : g_nopresc
            assign tick = 1'b1;
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        presc_nxt = presc;
        done_nxt  = 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
        reload_nxt = reload;
`endif
        if (load) begin
            count_nxt = load_val;
            presc_nxt = '0;
            state_nxt = IDLE;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
            reload_nxt = load_val;
`endif
        end else if (state == IDLE) begin
            if (start) begin
                if (count != '0) begin
                    state_nxt = RUN;
                    presc_nxt = '0;
                end else begin
                    // Zero-length run: report completion without entering RUN.
                    done_nxt = 1'b1;
                end
            end
        end else if (en && (count != '0)) begin
            if (tick) begin
                presc_nxt = '0;
                if (count == WIDTH'(1)) begin
                    done_nxt = 1'b1;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
                    if (reload != '0) begin
                        count_nxt = reload;
                    end else begin
                        count_nxt = '0;
                        state_nxt = IDLE;
                    end
`else
                    count_nxt = '0;
                    state_nxt = IDLE;
`endif
                end else begin
                    count_nxt = count - WIDTH'(1);
                end
            end else begin
                presc_nxt = presc + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            presc <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
            reload <= '0;
`endif
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            presc <= presc_nxt;
            busy  <= (state_nxt == RUN);
            done  <= done_nxt;
`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
            reload <= reload_nxt;
`endif
        end
    end

    assign zero = (count == '0);

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed bench for down_counter_timer: one instance at PRESCALE=1, one at PRESCALE=3.
module tb_down_counter_timer;

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       en1 = 1'b0, load1 = 1'b0, start1 = 1'b0;
    logic [3:0] lv1 = '0;
    logic [3:0] count1;
    logic       busy1, done1, zero1;

    logic       en3 = 1'b0, load3 = 1'b0, start3 = 1'b0;
    logic [3:0] lv3 = '0;
    logic [3:0] count3;
    logic       busy3, done3, zero3;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    down_counter_timer #(.WIDTH(4), .PRESCALE(1)) u1 (
        .clk(clk), .rst(rst), .en(en1), .load(load1), .load_val(lv1), .start(start1),
        .count(count1), .busy(busy1), .done(done1), .zero(zero1)
    );

    down_counter_timer #(.WIDTH(4), .PRESCALE(3)) u3 (
        .clk(clk), .rst(rst), .en(en3), .load(load3), .load_val(lv3), .start(start3),
        .count(count3), .busy(busy3), .done(done3), .zero(zero3)
    );

    typedef struct {
        logic       load;
        logic [3:0] lv;
        logic       start;
        logic       en;
        logic [3:0] c;
        logic       b;
        logic       d;
        logic       z;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int ld, int lv, int st, int e, int c, int b, int d, int z);
        vec_t r;
        r.load = ld[0]; r.lv = lv[3:0]; r.start = st[0]; r.en = e[0];
        r.c = c[3:0]; r.b = b[0]; r.d = d[0]; r.z = z[0];
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input int c, input int b, input int d, input int z);
        chk({nm, ".count"}, int'(count1), c);
        chk({nm, ".busy"}, int'(busy1), b);
        chk({nm, ".done"}, int'(done1), d);
        chk({nm, ".zero"}, int'(zero1), z);
    endtask

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    // PRESCALE=3 run of count 2; optional en drop for 4 cycles mid-run.
    task automatic run3(input bit drop);
        int ec;
        int ec_c;
        int last;
        load3 = 1'b1; lv3 = 4'd2; en3 = 1'b1;
        edge1();
        load3 = 1'b0; start3 = 1'b1;
        edge1();
        chk("p3.start.count", int'(count3), 2);
        chk("p3.start.busy", int'(busy3), 1);
        start3 = 1'b0;
        ec = 0;
        last = drop ? 10 : 6;
        for (int k = 1; k <= last; k++) begin
            en3 = !(drop && k >= 3 && k <= 6);
            edge1();
            if (en3) ec++;
            ec_c = (ec >= 6) ? (AR ? 2 : 0) : 2 - ec / 3;
            chk($sformatf("p3.d%0d.k%0d.count", drop, k), int'(count3), ec_c);
            chk($sformatf("p3.d%0d.k%0d.done", drop, k), int'(done3), (ec == 6 && en3) ? 1 : 0);
            chk($sformatf("p3.d%0d.k%0d.busy", drop, k), int'(busy3), (AR || ec < 6) ? 1 : 0);
        end
    endtask

    initial begin
        tbl.push_back(mk(1, 5, 0, 1, 5, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 5, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 4, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 3, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, AR ? 5 : 0, AR, 1, !AR));
        tbl.push_back(mk(0, 0, 0, 1, AR ? 4 : 0, AR, 0, !AR));
        tbl.push_back(mk(1, 4, 1, 1, 4, 0, 0, 0));   // load wins over start
        tbl.push_back(mk(0, 0, 0, 1, 4, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 4, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 3, 1, 0, 0));
        tbl.push_back(mk(1, 9, 0, 1, 9, 0, 0, 0));   // abort: no done
        tbl.push_back(mk(0, 0, 0, 1, 9, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 1));   // zero-length run
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 15, 0, 1, 15, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 15, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 15, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 15, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 14, 1, 0, 0));  // start in RUN ignored

        #12;
        chk1("rst", 0, 0, 0, 1);
        chk("rst.count3", int'(count3), 0);
        chk("rst.zero3", int'(zero3), 1);
        rst = 1'b0;

        foreach (tbl[i]) begin
            load1 = tbl[i].load; lv1 = tbl[i].lv; start1 = tbl[i].start; en1 = tbl[i].en;
            edge1();
            chk1($sformatf("vec%0d", i), tbl[i].c, tbl[i].b, tbl[i].d, tbl[i].z);
        end
        load1 = 1'b0; start1 = 1'b0; en1 = 1'b1;

        // Run from 14 down to terminal: no wrap below zero.
        for (int k = 1; k <= 14; k++) begin
            edge1();
            if (k == 14)
                chk1($sformatf("max.k%0d", k), AR ? 15 : 0, AR, 1, !AR);
            else
                chk1($sformatf("max.k%0d", k), 14 - k, 1, 0, 0);
        end
        edge1();
        chk1("max.after", AR ? 14 : 0, AR, 0, !AR);

`ifdef DOWN_COUNTER_TIMER_AUTO_RELOAD_EN
        load1 = 1'b1; lv1 = 4'd3;
        edge1();
        load1 = 1'b0; start1 = 1'b1;
        edge1();
        chk1("ar.start", 3, 1, 0, 0);
        start1 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            edge1();
            chk1($sformatf("ar.k%0d", k), 3 - (k % 3), 1, (k % 3 == 0) ? 1 : 0, 0);
        end
        load1 = 1'b1; lv1 = 4'd0;
        edge1();
        load1 = 1'b0;
        chk1("ar.stop", 0, 0, 0, 1);
        edge1();
        chk1("ar.stop2", 0, 0, 0, 1);
`endif

        // Asynchronous reset in the middle of a run.
        load1 = 1'b1; lv1 = 4'd7;
        edge1();
        load1 = 1'b0; start1 = 1'b1;
        edge1();
        start1 = 1'b0;
        chk1("pre_rst", 7, 1, 0, 0);
        #2 rst = 1'b1;
        #1;
        chk1("async_rst", 0, 0, 0, 1);
        #2 rst = 1'b0;
        edge1();
        chk1("post_rst", 0, 0, 0, 1);

        run3(1'b0);
        run3(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/down_counter_timer.md
Name: down_counter_timer

Overview:
Loadable down-counting timer with a start/done handshake and a clock prescaler. It is the countdown counterpart of the team's up-counter. A controller loads a terminal value, starts the timer, and gets a one-cycle done pulse when the count reaches zero. It is used for timeouts and delay generation alongside free-running up-counters in the same clock domain.

Parameters:
WIDTH, 4, width of count, load_val and internal reload register
PRESCALE, 1, enabled clk cycles per decrement; legal range >= 1

Ports:
clk  input  1  clock; all state updates on its rising edge
rst  input  1  reset, asynchronous, active-high
en  input  1  count enable; when low, the prescaler and count freeze
load  input  1  load request, sampled on the clk rising edge
load_val  input  WIDTH  value captured on load
start  input  1  start request, sampled on the clk rising edge
count  output  WIDTH  current count, registered
busy  output  1  high while in RUN, registered
done  output  1  one-cycle pulse on terminal count, registered
zero  output  1  combinational (count == 0)

Behaviour:
- Reset (async, immediate): state=IDLE, count=0, reload reg=0, prescaler=0, busy=0, done=0; hence zero=1.
- States: IDLE, RUN. busy=1 exactly when state is RUN.
- done defaults to 0 every cycle; it is high for only the single cycle stated below.
- Priority each edge: load > start > tick.
- load=1, any state:
  - count<=load_val, reload<=load_val, prescaler<=0, state<=IDLE.
  - A RUN in progress is aborted with no done pulse.
  - start in the same cycle is ignored.
- start=1 in IDLE, load=0:
  - If count!=0: state<=RUN, prescaler<=0.
  - If count==0: stay IDLE, done=1 next cycle (zero-length run).
- start=1 while in RUN is ignored.
- Tick: in RUN with en=1, prescaler increments.
  - When prescaler==PRESCALE-1: prescaler<=0, count<=count-1.
  - PRESCALE=1 means a tick every enabled cycle; no prescaler register is needed.
- Terminal tick (tick with count==1): count<=0, state<=IDLE, done=1 for the following cycle, busy falls on the same edge.
- Latency: start accepted at edge E0 with count=N gives done high during the cycle after edge E0+N*PRESCALE, provided en is held high.
- en=0 in RUN: count and prescaler hold, busy stays 1. Resume continues from the frozen prescaler value.
- The count never decrements below 0 and never wraps. Decrement occurs only in RUN with count>0.
- Width rules: load_val is captured at full WIDTH. Max count is 2^WIDTH-1. Decrement is modulo-free by construction.
- Reset asserted mid-RUN: immediate return to reset values, no done pulse.

Optional Feature:
Macro DOWN_COUNTER_TIMER_AUTO_RELOAD_EN.
- Defined:
  - Terminal tick sets count<=reload and stays in RUN, busy=1, with done pulsing once per period. This gives a periodic done every reload*PRESCALE enabled cycles.
  - If reload==0, behaves as undefined-macro (goes IDLE).
  - load is the only way to stop a run.
- Undefined: terminal tick goes to IDLE with count=0 as above; the reload register may be optimised away.

Test Plan:
- Reset: assert rst mid-cycle with count=7 in RUN -> count=0, busy=0, done=0, zero=1 immediately, without waiting for a clock edge.
- One-shot, PRESCALE=1: load 5, then start with en=1 -> count 5,4,3,2,1,0 on successive edges; done high exactly 5 cycles after the start edge, for 1 cycle; busy low the same cycle.
- Prescaler, PRESCALE=3: load 2, start -> decrement every 3rd cycle; done at start+6; drop en for 4 cycles mid-run -> done at start+10.
- Simultaneous and abort: load=1 and start=1 together with load_val=4 -> count=4, IDLE, no run. Later load 9 during RUN at count=3 -> count=9, IDLE, no done.
- Boundaries: start with count=0 -> done pulse next cycle, busy never rises. Load 15 (WIDTH=4), run to completion -> no wrap, ends at 0.
- Auto-reload (macro defined), PRESCALE=1, load 3: start -> done pulses at +3, +6, +9 with count sequence 3,2,1,3,2,1...; load 0 -> IDLE.
